// File: rtl/ram_loader.sv
// Boot loader: packs a little-endian byte stream into WIDTH-bit words and
// writes them to consecutive RAM words. Optional trailing XOR checksum via RAM_LOADER_CHECKSUM_EN.
//
// state    | meaning
// S_IDLE   | waiting for start, outputs quiet
// S_HEADER | collecting the 4-byte word count
// S_DATA   | shifting bytes of the current word into wdata
// S_WRITE  | single enw cycle for the assembled word
// S_CHECK  | collecting the trailing checksum byte
// S_DONE   | load finished, done held until the next start
module ram_loader #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2048,
  parameter int BASE  = 0
) (
  input  logic             clock,
  input  logic             nreset,
  input  logic             start,
  input  logic [7:0]       byte_data,
  input  logic             byte_valid,
  output logic             byte_ready,
  output logic [WIDTH-1:0] address,
  output logic [WIDTH-1:0] wdata,
  output logic             enw,
  output logic             busy,
  output logic             done,
  output logic             error
);

  localparam int BPW = WIDTH / 8;

  typedef enum logic [2:0] {S_IDLE, S_HEADER, S_DATA, S_WRITE, S_CHECK, S_DONE} state_t;

  state_t      state, next_state;
  logic [23:0] hdr;
  logic [31:0] n_next;
  logic [31:0] word_n;
  logic [31:0] idx;
  logic [7:0]  byte_cnt;
  logic        wrote;
  logic        accept;
`ifdef RAM_LOADER_CHECKSUM_EN
  logic [7:0]  csum;
`endif

  assign byte_ready = (state == S_HEADER) || (state == S_DATA) || (state == S_CHECK);
  assign busy       = byte_ready || (state == S_WRITE);
  assign done       = (state == S_DONE);
  assign accept     = byte_valid && byte_ready;
  assign n_next     = {byte_data, hdr};

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) state <= S_IDLE;
    else         state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:   if (start) next_state = S_HEADER;
      S_HEADER: if (accept && byte_cnt == 8'd3) begin
                  if (n_next == 32'd0 || n_next > 32'(DEPTH)) next_state = S_DONE;
                  else                                        next_state = S_DATA;
                end
      S_DATA:   if (accept && byte_cnt == 8'(BPW - 1)) next_state = S_WRITE;
      S_WRITE: begin
`ifdef RAM_LOADER_CHECKSUM_EN
        if (idx + 32'd1 < word_n) next_state = S_DATA;
        else                      next_state = S_CHECK;
`else
        if (idx + 32'd1 < word_n) next_state = S_DATA;
        else                      next_state = S_DONE;
`endif
      end
      S_CHECK:  if (accept) next_state = S_DONE;
      S_DONE:   if (start) next_state = S_HEADER;
      default:  next_state = S_IDLE;
    endcase
  end

  // Address advances only when the next word's first byte arrives, so the
  // RAM sees a stable address/data through enw and the cycle after it.
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      hdr      <= '0;
      word_n   <= '0;
      idx      <= '0;
      byte_cnt <= '0;
      wrote    <= 1'b0;
      address  <= WIDTH'(BASE);
      wdata    <= '0;
      enw      <= 1'b0;
      error    <= 1'b0;
`ifdef RAM_LOADER_CHECKSUM_EN
      csum     <= '0;
`endif
    end else begin
      enw <= (next_state == S_WRITE);
      case (state)
        S_IDLE, S_DONE: if (start) begin
          byte_cnt <= '0;
          idx      <= '0;
          wrote    <= 1'b0;
          address  <= WIDTH'(BASE);
          wdata    <= '0;
          error    <= 1'b0;
`ifdef RAM_LOADER_CHECKSUM_EN
          csum     <= '0;
`endif
        end
        S_HEADER: if (accept) begin
          hdr <= n_next[31:8];
          if (byte_cnt == 8'd3) begin
            byte_cnt <= '0;
            word_n   <= n_next;
            if (n_next > 32'(DEPTH)) error <= 1'b1;
          end else begin
            byte_cnt <= byte_cnt + 8'd1;
          end
        end
        S_DATA: if (accept) begin
          wdata <= (wdata >> 8) | (WIDTH'(byte_data) << (WIDTH - 8));
          if (byte_cnt == 8'(BPW - 1)) byte_cnt <= '0;
          else                         byte_cnt <= byte_cnt + 8'd1;
          if (byte_cnt == 8'd0 && wrote) begin
            idx     <= idx + 32'd1;
            address <= address + WIDTH'(1);
          end
`ifdef RAM_LOADER_CHECKSUM_EN
          csum <= csum ^ byte_data;
`endif
        end
        S_WRITE: wrote <= 1'b1;
        S_CHECK: begin
`ifdef RAM_LOADER_CHECKSUM_EN
          if (accept && byte_data != csum) error <= 1'b1;
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_loader.sv
// Directed bench for ram_loader: scoreboard of expected writes checked by a
// RAM-port monitor, plus direct status checks after each step.
module tb_ram_loader;

  localparam int W    = 32;
  localparam int BASE = 16;

  logic         clock = 1'b0;
  logic         nreset, start, byte_valid, byte_ready, enw, busy, done, error;
  logic [7:0]   byte_data;
  logic [W-1:0] address, wdata;

  ram_loader #(.WIDTH(W), .DEPTH(2048), .BASE(BASE)) dut (
    .clock(clock), .nreset(nreset), .start(start), .byte_data(byte_data),
    .byte_valid(byte_valid), .byte_ready(byte_ready), .address(address),
    .wdata(wdata), .enw(enw), .busy(busy), .done(done), .error(error)
  );

  always #5 clock = ~clock;

  typedef struct { logic [31:0] a; logic [31:0] d; } wr_t;
  wr_t         exp_q[$];
  logic [31:0] mem [int];
  int          tests = 0, fails = 0, enw_cnt = 0;
  int          exp_addr = BASE;
  logic [7:0]  csum = 8'h00;
  logic        rnd_start = 1'b0;
  logic        stab_pend = 1'b0;
  logic [31:0] last_a, last_d;
  logic [31:0] w [5];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // RAM port monitor: applies writes to the model and checks them against the scoreboard.
  initial begin
    wr_t e;
    forever begin
      @(negedge clock);
      if (!nreset) stab_pend = 1'b0;
      else if (stab_pend) begin
        check("stable_addr", address, last_a);
        check("stable_wdata", wdata, last_d);
        check("enw_one_cycle", enw, 1'b0);
        stab_pend = 1'b0;
      end else if (enw) begin
        enw_cnt++;
        mem[int'(address)] = wdata;
        check("wr_expected", 64'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("wr_addr", address, e.a);
          check("wr_data", wdata, e.d);
        end
        last_a = address;
        last_d = wdata;
        stab_pend = 1'b1;
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    exp_addr = BASE;
    csum = 8'h00;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    for (int i = 0; i < gap; i++) begin
      start = rnd_start && ($urandom_range(0, 2) == 0);
      @(negedge clock);
    end
    start = 1'b0;
    byte_valid = 1'b1;
    byte_data = b;
    n = 0;
    while (!byte_ready && n < 100) begin
      @(negedge clock);
      n++;
    end
    if (n >= 100) check("byte_accept_timeout", byte_ready, 1'b1);
    @(negedge clock);
    byte_valid = 1'b0;
  endtask

  task automatic send_header(input logic [31:0] n, input int gap);
    for (int i = 0; i < 4; i++) send_byte(n[8*i +: 8], gap);
  endtask

  task automatic send_word(input logic [31:0] d, input int gap);
    wr_t e;
    e.a = 32'(exp_addr);
    e.d = d;
    exp_q.push_back(e);
    exp_addr++;
    for (int i = 0; i < 4; i++) begin
      csum = csum ^ d[8*i +: 8];
      send_byte(d[8*i +: 8], gap);
    end
    check("write_enw", enw, 1'b1);
    check("write_not_ready", byte_ready, 1'b0);
  endtask

  task automatic send_trailer();
`ifdef RAM_LOADER_CHECKSUM_EN
    send_byte(csum, 0);
`endif
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 50) begin
      @(negedge clock);
      n++;
    end
    check("done", done, 1'b1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_byte_ready"}, byte_ready, 1'b0);
    check({tag, "_address"}, address, 32'(BASE));
    check({tag, "_wdata"}, wdata, 32'h0);
    check({tag, "_enw"}, enw, 1'b0);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_done"}, done, 1'b0);
    check({tag, "_error"}, error, 1'b0);
  endtask

  initial begin
    int e0;
    nreset = 1'b1; start = 1'b0; byte_valid = 1'b0; byte_data = 8'h00;
    #2 nreset = 1'b0;
    repeat (2) @(negedge clock);
    check_reset_outputs("reset");
    nreset = 1'b1;
    @(negedge clock);

    // basic two-word load
    pulse_start();
    check("start_busy", busy, 1'b1);
    check("start_ready", byte_ready, 1'b1);
    e0 = enw_cnt;
    send_header(32'd2, 0);
    send_word(32'h12345678, 0);
    send_word(32'hDEADBEEF, 0);
    send_trailer();
    wait_done();
    check("t1_error", error, 1'b0);
    check("t1_busy", busy, 1'b0);
    check("t1_ready", byte_ready, 1'b0);
    check("t1_writes", enw_cnt - e0, 2);
    check("t1_mem0", mem[BASE], 32'h12345678);
    check("t1_mem1", mem[BASE+1], 32'hDEADBEEF);
    check("t1_queue", exp_q.size(), 0);

    // zero-length load
    pulse_start();
    e0 = enw_cnt;
    send_header(32'd0, 0);
    check("t2_done", done, 1'b1);
    check("t2_busy", busy, 1'b0);
    repeat (3) @(negedge clock);
    check("t2_writes", enw_cnt - e0, 0);

    // oversize count
    pulse_start();
    e0 = enw_cnt;
    send_header(32'd2049, 0);
    check("t3_done", done, 1'b1);
    check("t3_error", error, 1'b1);
    repeat (3) @(negedge clock);
    check("t3_writes", enw_cnt - e0, 0);

    // gapped stream with stray start pulses
    pulse_start();
    check("t4_error_cleared", error, 1'b0);
    check("t4_done_cleared", done, 1'b0);
    mem.delete();
    rnd_start = 1'b1;
    foreach (w[i]) w[i] = $urandom;
    send_header(32'd5, 2);
    foreach (w[i]) send_word(w[i], $urandom_range(0, 3));
    send_trailer();
    rnd_start = 1'b0;
    wait_done();
    check("t4_error", error, 1'b0);
    foreach (w[i]) check("t4_mem", mem[BASE+i], w[i]);
    check("t4_queue", exp_q.size(), 0);

    // reset in the middle of a three-word load
    pulse_start();
    send_header(32'd3, 0);
    send_word(32'hA5A50001, 0);
    repeat (3) @(negedge clock);
    #3 nreset = 1'b0;
    #1 check_reset_outputs("midreset");
    @(negedge clock);
    nreset = 1'b1;
    exp_q.delete();
    mem.delete();
    @(negedge clock);
    pulse_start();
    send_header(32'd3, 0);
    send_word(32'h11111111, 1);
    send_word(32'h22222222, 0);
    send_word(32'h33333333, 1);
    send_trailer();
    wait_done();
    check("t5_error", error, 1'b0);
    check("t5_mem0", mem[BASE], 32'h11111111);
    check("t5_mem1", mem[BASE+1], 32'h22222222);
    check("t5_mem2", mem[BASE+2], 32'h33333333);

`ifdef RAM_LOADER_CHECKSUM_EN
    pulse_start();
    mem.delete();
    send_header(32'd1, 0);
    send_word(32'h04030201, 0);
    send_byte(8'h04, 0);
    wait_done();
    check("cs_good_error", error, 1'b0);
    check("cs_good_mem", mem[BASE], 32'h04030201);

    pulse_start();
    mem.delete();
    send_header(32'd1, 0);
    send_word(32'h04030201, 0);
    send_byte(8'h05, 0);
    wait_done();
    check("cs_bad_error", error, 1'b1);
    check("cs_bad_mem", mem[BASE], 32'h04030201);
`endif

    repeat (3) @(negedge clock);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ram_loader.md
# ram_loader

Boot-time program/data loader that sits directly upstream of the SoC's dual-port RAM and drives one of its write ports. It accepts a byte stream (from the UART receiver or a test harness), packs bytes little-endian into WIDTH-bit words and writes them to consecutive word addresses. While loading, it holds the CPU off the RAM. Word addressing matches the RAM: the address increments by 1 per word.

## Interface
- WIDTH, 32: RAM data/address width; must be a multiple of 8.
- DEPTH, 2048: RAM depth in words; upper bound on the word count.
- BASE, 0: first word address written.
- clock  in  1  system clock; all state changes on the rising edge.
- nreset  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle pulse; begins a load when idle or done.
- byte_data  in  8  stream byte.
- byte_valid  in  1  byte_data is valid.
- byte_ready  out  1  loader can accept a byte. A transfer occurs on an edge where valid and ready are both high.
- address  out  WIDTH  RAM word address (registered).
- wdata  out  WIDTH  RAM write data (registered).
- enw  out  1  RAM write enable (registered, one cycle per word).
- busy  out  1  load in progress; holds the CPU in reset.
- done  out  1  load finished; sticky until the next start.
- error  out  1  load failed; sticky until the next start.

## Operation
- The bus is already fixed: one clock; reset is asynchronous and active-low.
- Frame format:
  - 4-byte little-endian header giving the word count N.
  - N words of WIDTH/8 bytes each, little-endian.
  - Optional checksum byte (see Configuration).
- States: IDLE, HEADER, DATA, WRITE, CHECK, DONE.
  - IDLE: all outputs low. start -> HEADER, with byte counter and word index cleared.
  - HEADER: byte_ready=1. After the 4th byte:
    - N=0 -> DONE, no writes.
    - N>DEPTH -> DONE with error=1, no writes.
    - otherwise -> DATA.
  - DATA: byte_ready=1; bytes are shifted into wdata, first byte into bits [7:0]. After the (WIDTH/8)th byte -> WRITE.
  - WRITE: one cycle with enw=1 and byte_ready=0. Then:
    - index+1 < N -> DATA.
    - otherwise -> CHECK if the macro is defined, else DONE.
  - CHECK: byte_ready=1. Accepts 1 byte, compares it with the running checksum, sets error on mismatch, then -> DONE.
  - DONE: done=1, busy=0, byte_ready=0. start clears done/error and -> HEADER.
- address = BASE + index.
  - The index increments on the edge the first byte of the next word is accepted, never on the edge enw falls. This is required because the RAM write is level-sensitive: address and wdata must be stable for the whole enw-high cycle and for at least one cycle after it.
- wdata is not modified while enw=1.
- busy = 1 in HEADER, DATA, WRITE and CHECK.
- start while busy is ignored. Bytes offered in IDLE or DONE are not accepted (byte_ready=0).

## Timing
- Reset values: byte_ready=0, address=BASE, wdata=0, enw=0, busy=0, done=0, error=0. State = IDLE.
- start sampled at edge t -> busy=1 and byte_ready=1 after edge t.
- Last byte of a word accepted at edge k -> enw=1 and byte_ready=0 from edge k to edge k+1. Earliest next byte accepted at edge k+2.
  - Peak throughput is 4 bytes per 5 cycles at WIDTH=32.
- The final WRITE (or CHECK) completes at edge m -> done=1 and busy=0 after edge m.
- byte_valid may drop at any time. The loader waits indefinitely, with no timeout.
- Reset mid-load: outputs return to reset values immediately (asynchronous). Words already written remain in RAM; the next load starts from the header.
- The address never exceeds BASE+N-1. N=DEPTH is legal.

## Configuration
- RAM_LOADER_CHECKSUM_EN defined:
  - An 8-bit XOR of all data bytes (header excluded) is accumulated.
  - One trailing checksum byte is expected; mismatch -> error=1 in DONE. The words are still written.
- Not defined: there is no CHECK state and no trailing byte. error is set only for N>DEPTH.

## Test plan
- Reset then header 02 00 00 00, data 78 56 34 12 EF BE AD DE -> writes 0x12345678 at BASE and 0xDEADBEEF at BASE+1. Each write has exactly one enw cycle; done=1, error=0.
- Header 00 00 00 00 -> no enw pulse; done=1 right after the 4th byte.
- Header with N=2049 (01 08 00 00) at DEPTH=2048 -> error=1, done=1, no enw.
- Random byte_valid gaps and start pulses during the load -> identical RAM contents. The start pulses are ignored. address/wdata are stable across every enw cycle and the cycle after it.
- nreset asserted after 1 of 3 words -> all outputs at reset values. A restarted 3-word load writes BASE..BASE+2 correctly.
- With RAM_LOADER_CHECKSUM_EN, N=1, data 01 02 03 04:
  - checksum byte 04 -> error=0.
  - checksum byte 05 -> error=1; the word is still written.
